// File: rtl/counter_pkg.sv
// Purpose : shared types and constants for the counter block family.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

   localparam int COUNTER_WIDTH = 128;

   // Two-state countdown control: counting, or parked at zero after a
   // terminal event without auto-reload.
   typedef enum logic {
      RUN     = 1'b0,
      STOPPED = 1'b1
   } cnt_state_t;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ALL_ONES = '1;

endpackage : counter_pkg

// File: rtl/down_counter_128bit_async_reset.sv
// Purpose : loadable down counter with terminal-count pulse and optional auto-reload.
// Latency : load/decrement visible on o_result 1 cycle later; o_expired 1 cycle after terminal event.
// Backpressure: none; i_enable qualifies each decrement, no stall path.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_load         load i_load_value into count and reload register (beats counting)
//   i_load_value   value captured on i_load
//   i_enable       decrement qualifier
//   i_auto_reload  on terminal event: 1 = reload and run, 0 = stop at zero
//   o_result       current count (register)
//   o_zero         o_result == 0 (decode of register)
//   o_expired      one-cycle registered pulse after a terminal event
module down_counter_128bit_async_reset
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_enable,
   input  logic             i_auto_reload,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_expired
);

   cnt_state_t       r_state;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_reload;
   logic             r_expired;

   cnt_state_t       w_state_nxt;
   logic [WIDTH-1:0] w_result_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_expired_nxt;
   logic             w_at_zero;

   assign w_at_zero = (r_result == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= RUN;
         r_result  <= '1;
         r_reload  <= '1;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_result  <= w_result_nxt;
         r_reload  <= w_reload_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_result_nxt  = r_result;
      w_reload_nxt  = r_reload;
      w_expired_nxt = 1'b0;

      if (i_load) begin
         // Load overrides any terminal condition in the same cycle, so no pulse.
         w_result_nxt = i_load_value;
         w_reload_nxt = i_load_value;
         w_state_nxt  = RUN;
      end else begin
         case (r_state)
            RUN: begin
               if (i_enable) begin
                  if (w_at_zero) begin
                     // Terminal event: zero is intercepted here, never decremented.
                     w_expired_nxt = 1'b1;
                     if (i_auto_reload) begin
                        w_result_nxt = r_reload;
                     end else begin
                        w_state_nxt = STOPPED;
                     end
                  end else begin
                     w_result_nxt = r_result - WIDTH'(1);
                  end
               end
            end
            STOPPED: begin
               // Parked at zero; only load or reset leaves this state.
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end
   end

   assign o_result  = r_result;
   assign o_zero    = w_at_zero;
   assign o_expired = r_expired;

endmodule : down_counter_128bit_async_reset

// File: doc/down_counter_128bit_async_reset.md
# down_counter_128bit_async_reset

Loadable 128-bit down counter with terminal-count detection and optional auto-reload. It counts in the opposite direction to the counters block family's free-running up counter. It serves as the countdown/timeout end of a counter pair: a value is loaded, decremented on enabled cycles, and a one-cycle `expired` pulse flags the terminal event. Single clock domain; asynchronous active-high reset.

## Interface
- `WIDTH`, default 128, counter and load-value width.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset. Asserting it clears state immediately, independent of `clk`; deassertion is synchronous to `clk` upstream.
- `load` in 1: load `load_value` into the counter and the reload register.
- `load_value` in WIDTH: value captured when `load`=1.
- `enable` in 1: decrement qualifier.
- `auto_reload` in 1: on the terminal event, 1 = reload and keep running, 0 = stop.
- `result` out WIDTH: current count (register).
- `zero` out 1: `result` == 0 (decode of register, no added latency).
- `expired` out 1: one-cycle registered pulse following a terminal event.

## Operation
- States: `RUN`, `STOPPED`. State register, `result`, `reload_reg`, `expired` are all flops on the async reset.
- Reset values:
  - `result` = all ones (2^WIDTH−1).
  - `reload_reg` = all ones.
  - state = `RUN`.
  - `expired` = 0.
  - `zero` = 0.
- Priority per cycle: reset > `load` > count.
- `load`=1, either state:
  - `result` ← `load_value`, `reload_reg` ← `load_value`, state ← `RUN`, `expired` ← 0.
  - `enable` is ignored that cycle.
- `RUN`, `enable`=1, `result` ≠ 0: `result` ← `result` − 1, `expired` ← 0.
- `RUN`, `enable`=1, `result` = 0 (terminal event): `expired` ← 1.
  - `auto_reload`=1: `result` ← `reload_reg`, stay `RUN`.
  - `auto_reload`=0: `result` stays 0, state ← `STOPPED`.
- `RUN`, `enable`=0: hold `result`; `expired` ← 0.
- `STOPPED`:
  - Hold `result` = 0; `enable` and `auto_reload` are ignored; `expired` ← 0.
  - Exit only via `load` or reset.
- Arithmetic:
  - Decrement is unsigned, WIDTH bits.
  - The counter never wraps below 0; the terminal event intercepts 0.
  - Full WIDTH carry chain; no truncation.
- Boundary cases:
  - `load_value` = 0: `zero`=1 the next cycle; the next enabled cycle is a terminal event.
  - `auto_reload`=1 with `reload_reg` = 0: terminal event on every enabled cycle, so `expired` stays high continuously while `enable`=1.
  - `load` in the same cycle as a terminal condition: the load wins and no `expired` is generated.
  - Reset mid-count or mid-`expired` pulse: all outputs return to reset values asynchronously.
  - `auto_reload` is sampled only at the terminal event.

## Timing
- Load to `result`: 1 cycle.
- Enable to decremented `result`: 1 cycle.
- Terminal event (cycle N, `result`=0, `enable`=1) to `expired`=1 in cycle N+1. In that same cycle N+1, `result` holds the reload value (auto-reload) or 0 (stopped).
- Period with `auto_reload`=1 and `enable` held at 1: V+1 cycles between `expired` pulses for reload value V.
- `zero` is combinational from the `result` register: same cycle as `result`.
- No combinational input-to-output paths.

## Structure
- Shared package `counter_pkg`:
  - `COUNTER_WIDTH` = 128.
  - State enum `cnt_state_t` {`RUN`, `STOPPED`}.
  - Constant `CNT_ALL_ONES`.
- Single module; no sub-module needed. The decrement, reload mux and zero decode stay inline.

## Test plan
- Reset then `enable`=1 for 3 cycles → `result` = 2^128−4, `zero`=0, `expired`=0. Assert reset mid-run → `result` = all ones immediately, before the next clock edge.
- Load 5, `auto_reload`=0, `enable`=1 continuously:
  - `result` sequence 5,4,3,2,1,0.
  - `expired`=1 exactly one cycle, in the cycle after the enabled cycle at 0.
  - Then `STOPPED`, `result` holds 0, `enable` has no effect.
- Load 2, `auto_reload`=1, `enable`=1 for 10 cycles → `result` 2,1,0,2,1,0,…, with an `expired` pulse every 3 cycles.
- Load 0 → `zero`=1. Pulse `enable` once → `expired`=1 next cycle. With `auto_reload`=1 and `enable` held → `expired` stays 1.
- `result`=0 in `RUN`, `enable`=1 and `load`=1 with value 7 in the same cycle → `result`=7, no `expired`. Toggle `enable` 1,0,1 → `result` 7,6,6,5.
- Load 2^128−1 then `enable` once → `result` = 2^128−2, confirming the upper bits carry correctly.
